// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack handshake, and presents Instr/PC to decode.
// Optional misaligned-target trap (misalign output, HALT state) enabled by FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
  parameter int unsigned         XLEN     = 32,
  parameter logic [XLEN-1:0]     RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ack,
  output logic [XLEN-1:0] Instr,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            instr_valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misalign
`endif
);

  localparam logic [XLEN-1:0] Nop = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StExec
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    StHalt
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4 = pc_q + XLEN'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= Nop;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        if (!stall) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (PCSrc && (PCTarget[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
            state_d    = StHalt;
          end else begin
            pc_d    = PCSrc ? PCTarget : pc_plus4;
            state_d = StFetch;
          end
`else
          pc_d    = PCSrc ? PCTarget : pc_plus4;
          state_d = StFetch;
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      // Only rst leaves HALT.
      StHalt: state_d = StHalt;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Request is decoded from the async-reset state, so rst drops it immediately.
  always_comb begin
    imem_req    = (state_q == StFetch);
    imem_addr   = pc_q;
    instr_valid = (state_q == StExec);
    Instr       = instr_q;
    PC          = pc_q;
    PCPlus4     = pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign    = misalign_q;
`endif
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vectors, a cycle-level reference model,
// and a configurable-wait memory. Build with FETCH_MISALIGN_TRAP_EN to exercise the trap.
module tb_instr_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] NopWord = 32'h0000_0013;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = 32'h0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int unsigned wait_n = 0;
  int unsigned fetch_cnt = 0;
  logic        force_ack = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  instr_fetch_unit #(
    .XLEN    (32),
    .RESET_PC(ResetPc)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .PCSrc      (PCSrc),
    .PCTarget   (PCTarget),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .Instr      (Instr),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .instr_valid(instr_valid)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign   (misalign)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return {a[23:0], 8'h13};
  endfunction

  // Memory acks after wait_n wait cycles; force_ack injects a stray ack with junk data.
  always_comb begin
    imem_ack   = (imem_req && (fetch_cnt >= wait_n)) || force_ack;
    imem_rdata = force_ack ? 32'hDEAD_BEEF : word_at(imem_addr);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) fetch_cnt <= 0;
    else if (imem_req && !imem_ack) fetch_cnt <= fetch_cnt + 1;
    else fetch_cnt <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: phase 0 idle, 1 waiting for memory, 2 executing, 3 halted.
  int          m_ph = 0;
  logic [31:0] m_pc = ResetPc;
  logic [31:0] m_instr = NopWord;
  logic        m_mis = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = 0; m_pc = ResetPc; m_instr = NopWord; m_mis = 1'b0;
    end else if (m_ph == 0) begin
      m_ph = 1;
    end else if (m_ph == 1) begin
      if (imem_ack) begin m_instr = imem_rdata; m_ph = 2; end
    end else if (m_ph == 2 && !stall) begin
      if (TrapEn && PCSrc && PCTarget[1:0] != 2'b00) begin
        m_mis = 1'b1; m_ph = 3;
      end else begin
        m_pc = PCSrc ? PCTarget : m_pc + 32'd4;
        m_ph = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("m_imem_req", imem_req, m_ph == 1);
    check("m_instr_valid", instr_valid, m_ph == 2);
    check("m_pc", PC, m_pc);
    check("m_pcplus4", PCPlus4, m_pc + 32'd4);
    check("m_instr", Instr, m_instr);
    if (m_ph == 1) check("m_imem_addr", imem_addr, m_pc);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("m_misalign", misalign, m_mis);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !instr_valid; i++) tick();
    check("reach_exec", instr_valid, 1'b1);
  endtask

  initial begin
    int n;
    #1 rst = 1'b1;
    #11;
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_pc", PC, 32'h0);
    check("rst_instr", Instr, NopWord);
    check("rst_pcplus4", PCPlus4, 32'h4);
    tick();
    rst = 1'b0;

    // Sequential fetch, zero-wait memory
    wait_valid();
    check("seq_pc0", PC, 32'h0);
    check("seq_instr0", Instr, 32'h0050_0093);
    tick();
    check("seq_req4", imem_req, 1'b1);
    check("seq_addr4", imem_addr, 32'h4);
    check("seq_valid_gap", instr_valid, 1'b0);
    tick();
    check("seq_valid4", instr_valid, 1'b1);
    check("seq_pc4", PC, 32'h4);
    check("seq_instr4", Instr, 32'h0010_0113);

    // Three wait states on the fetch of 0x8
    wait_n = 3;
    tick();
    n = 0;
    for (int i = 0; i < 20 && imem_req; i++) begin
      n++;
      check("wait_instr_hold", Instr, 32'h0010_0113);
      check("wait_addr", imem_addr, 32'h8);
      tick();
    end
    check("wait_req_cycles", n, 4);
    check("wait_exec", instr_valid, 1'b1);
    check("wait_instr", Instr, word_at(32'h8));

    // Branches
    wait_n = 0;
    PCSrc = 1'b1; PCTarget = 32'h10;
    tick();
    check("br_addr10", imem_addr, 32'h10);
    wait_valid();
    PCTarget = 32'h40;
    tick();
    check("br_req40", imem_req, 1'b1);
    check("br_addr40", imem_addr, 32'h40);
    wait_valid();
    PCTarget = 32'h10;
    tick();
    wait_valid();
    check("br_pc10", PC, 32'h10);
    PCSrc = 1'b0;
    tick();
    check("nt_addr14", imem_addr, 32'h14);
    wait_valid();

    // Stall for 5 cycles with a moving target that must be ignored
    stall = 1'b1; PCSrc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      PCTarget = 32'h80 + 32'(i * 4);
      check("stall_valid", instr_valid, 1'b1);
      check("stall_pc", PC, 32'h14);
      check("stall_instr", Instr, word_at(32'h14));
      tick();
    end
    stall = 1'b0; PCSrc = 1'b0;
    check("stall_valid_last", instr_valid, 1'b1);
    tick();
    check("stall_next_addr", imem_addr, 32'h18);
    wait_valid();

    // Stray ack in EXEC is ignored
    stall = 1'b1; force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    check("stray_instr", Instr, word_at(32'h18));
    check("stray_valid", instr_valid, 1'b1);
    stall = 1'b0;

    // Wrap at top of address space
    PCSrc = 1'b1; PCTarget = 32'hFFFF_FFFC;
    tick();
    wait_valid();
    check("wrap_pc", PC, 32'hFFFF_FFFC);
    check("wrap_pcplus4", PCPlus4, 32'h0);
    PCSrc = 1'b0;
    tick();
    check("wrap_req", imem_req, 1'b1);
    check("wrap_addr", imem_addr, 32'h0);
    wait_valid();

    // Reset in the middle of a slow fetch
    wait_n = 5;
    tick();
    tick();
    check("midrst_req_before", imem_req, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_req", imem_req, 1'b0);
    check("midrst_pc", PC, ResetPc);
    check("midrst_instr", Instr, NopWord);
    tick();
    rst = 1'b0; force_ack = 1'b1; wait_n = 0;
    tick();
    force_ack = 1'b0;
    check("midrst_stray", Instr, NopWord);
    wait_valid();
    check("midrst_pc0", PC, 32'h0);
    check("midrst_instr0", Instr, 32'h0050_0093);

    // Misaligned target
    PCSrc = 1'b1; PCTarget = 32'h22;
    tick();
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      check("mis_flag", misalign, 1'b1);
      check("mis_req", imem_req, 1'b0);
      check("mis_valid", instr_valid, 1'b0);
      check("mis_pc", PC, 32'h0);
      tick();
    end
`else
    check("mis_req", imem_req, 1'b1);
    check("mis_addr", imem_addr, 32'h22);
    wait_valid();
    check("mis_pc", PC, 32'h22);
`endif
    PCSrc = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
